// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector shape, stop encodings, per-stage
// NOP payload constants and the per-edge event type of a pipeline register.
package pipe_pkg;

  localparam int unsigned STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_vec_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // ID/EX NOP fields: aluop, alusel and destination register address
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP  = 3'b000;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  // Low-order packing of the ID/EX NOP fields into a 128-bit payload
  localparam logic [127:0] ID_EX_NOP_DATA =
    128'({EXE_NOP_OP, EXE_RES_NOP, NOP_REG_ADDR});

  typedef enum logic [1:0] {
    FLUSH   = 2'd0,
    BUBBLE  = 2'd1,
    ADVANCE = 2'd2,
    HOLD    = 2'd3
  } pipe_evt_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage slot: upstream payload (in_*) and registered payload (out_*).
//  master: drives in_*, observes out_*   (upstream stage / bench)
//  slave : observes in_*, drives out_*   (the pipeline register)
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned STICKY_W = 1
);

  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic [STICKY_W-1:0] in_sticky;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [STICKY_W-1:0] out_sticky;

  modport master (
    output in_valid, in_data, in_sticky,
    input  out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_sticky,
    output out_valid, out_data, out_sticky
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
//  clk, rst (async active-low), inc: count enable, clr: zero (beats inc),
//  cnt: current count, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register driven by the CTRL stall vector and flush.
//  clk, rst (async active-low)
//  stall      : CTRL stall vector, bit STAGE = this slot, STAGE+1 = downstream
//  flush      : kill the slot
//  bus        : slave side of the slot (in_* captured, out_* registered)
//  stall_err  : pulse, non-monotonic stall pattern seen on the previous edge
//  cnt_clr    : synchronous clear of the event counters
//  bubble_cnt, flush_cnt, hold_cnt : saturating event counters
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       STICKY_W = 1,
  parameter int unsigned       STALL_W  = pipe_pkg::STALL_W,
  parameter int unsigned       STAGE    = 2,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus,
  output logic               stall_err,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  import pipe_pkg::*;

  // Reject out-of-range stage index and degenerate widths at elaboration
  if ((STAGE + 2 > STALL_W) || (DATA_W == 0) || (STICKY_W == 0) ||
      (STALL_W == 0) || (CNT_W == 0)) begin : g_bad_param
    $error("pipe_stage_reg: illegal parameters STAGE=%0d STALL_W=%0d", STAGE, STALL_W);
  end

  logic      s_c;
  logic      d_c;
  pipe_evt_e evt_c;

  assign s_c = (stall[STAGE] == STOP);
  assign d_c = (stall[STAGE+1] == STOP);

  // First-match priority: flush, bubble, advance, hold
  always_comb begin
    evt_c = ADVANCE;
    if (flush) begin
      evt_c = FLUSH;
    end else if (s_c && !d_c) begin
      evt_c = BUBBLE;
    end else if (!s_c) begin
      evt_c = ADVANCE;
    end else begin
      evt_c = HOLD;
    end
  end

  // Slot register; sticky sideband survives bubbles, cleared only by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_data   <= NOP_DATA;
      bus.out_valid  <= 1'b0;
      bus.out_sticky <= '0;
    end else begin
      case (evt_c)
        FLUSH: begin
          bus.out_data   <= NOP_DATA;
          bus.out_valid  <= 1'b0;
          bus.out_sticky <= '0;
        end
        BUBBLE: begin
          bus.out_data  <= NOP_DATA;
          bus.out_valid <= 1'b0;
        end
        ADVANCE: begin
          bus.out_data   <= bus.in_data;
          bus.out_valid  <= bus.in_valid;
          bus.out_sticky <= bus.in_sticky;
        end
        default: begin
        end
      endcase
    end
  end

  // Downstream stalled while this slot runs: flagged even under flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_err <= 1'b0;
    end else begin
      stall_err <= !s_c && d_c;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (evt_c == BUBBLE),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (evt_c == FLUSH),
    .clr (cnt_clr),
    .cnt (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (evt_c == HOLD),
    .clr (cnt_clr),
    .cnt (hold_cnt)
  );

endmodule
